// File: rtl/exu_wb_buffer.sv
// Two-entry FIFO between the ALU and writeback with registered head outputs and flush.
// Optional operand bypass lookup is enabled by defining EXU_WB_BYPASS_EN.
module exu_wb_buffer #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wen,
    input  logic [XLEN-1:0]   in_result,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wen,
    output logic [XLEN-1:0]   out_result,
    output logic [XLEN-1:0]   out_pc,
    output logic [1:0]        count
`ifdef EXU_WB_BYPASS_EN
   ,input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs1_hit,
    output logic              rs2_hit,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data
`endif
);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   pc;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t      slot_r [2];
    entry_t      slot_s [2];
    entry_t      head_r;
    entry_t      in_entry_s;
    logic        rptr_r, wptr_r, rptr_s, wptr_s;
    logic [1:0]  count_r, count_s;
    logic        out_valid_r, in_ready_r;
    logic        push_s, pop_s;

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // x0 is hardwired, so an entry targeting it never requests a write
    assign in_entry_s.rd     = in_rd;
    assign in_entry_s.wen    = in_wen & (in_rd != {REG_AW{1'b0}});
    assign in_entry_s.result = in_result;
    assign in_entry_s.pc     = in_pc;

    // Next-state: slot writes, pointer advance and occupancy; flush overrides everything
    always_comb begin
        slot_s[0] = slot_r[0];
        slot_s[1] = slot_r[1];
        rptr_s    = rptr_r;
        wptr_s    = wptr_r;
        count_s   = count_r;
        if (flush) begin
            rptr_s  = 1'b0;
            wptr_s  = 1'b0;
            count_s = 2'd0;
        end else begin
            if (push_s) begin
                slot_s[wptr_r] = in_entry_s;
                wptr_s         = ~wptr_r;
            end else begin
                wptr_s = wptr_r;
            end
            if (pop_s) begin
                rptr_s = ~rptr_r;
            end else begin
                rptr_s = rptr_r;
            end
            count_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // State and registered outputs; the head register holds its value while empty
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r[0]   <= {ENTRY_W{1'b0}};
            slot_r[1]   <= {ENTRY_W{1'b0}};
            head_r      <= {ENTRY_W{1'b0}};
            rptr_r      <= 1'b0;
            wptr_r      <= 1'b0;
            count_r     <= 2'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            slot_r[0]   <= slot_s[0];
            slot_r[1]   <= slot_s[1];
            rptr_r      <= rptr_s;
            wptr_r      <= wptr_s;
            count_r     <= count_s;
            out_valid_r <= (count_s != 2'd0);
            in_ready_r  <= (count_s != 2'd2);
            if (count_s != 2'd0) begin
                head_r <= slot_s[rptr_s];
            end else begin
                head_r <= head_r;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_rd     = head_r.rd;
    assign out_wen    = head_r.wen;
    assign out_result = head_r.result;
    assign out_pc     = head_r.pc;
    assign count      = count_r;

`ifdef EXU_WB_BYPASS_EN
    entry_t young_s, old_s;

    // The most recently written slot sits just behind the write pointer
    assign young_s = slot_r[~wptr_r];
    assign old_s   = slot_r[rptr_r];

    function automatic logic [XLEN:0] lookup(input logic [REG_AW-1:0] addr,
                                             input logic [1:0]        cnt,
                                             input entry_t            young,
                                             input entry_t            old);
        logic [XLEN:0] res;
        res = {1'b0, {XLEN{1'b0}}};
        if (addr == {REG_AW{1'b0}}) begin
            res = {1'b0, {XLEN{1'b0}}};
        end else if ((cnt != 2'd0) && young.wen && (young.rd == addr)) begin
            res = {1'b1, young.result};
        end else if ((cnt == 2'd2) && old.wen && (old.rd == addr)) begin
            res = {1'b1, old.result};
        end else begin
            res = {1'b0, {XLEN{1'b0}}};
        end
        return res;
    endfunction

    // Bypass lookup uses only stored state, so a flush-cycle lookup sees pre-flush contents
    always_comb begin
        {rs1_hit, rs1_data} = lookup(rs1_addr, count_r, young_s, old_s);
        {rs2_hit, rs2_data} = lookup(rs2_addr, count_r, young_s, old_s);
    end
`endif

endmodule

// File: tb/tb_exu_wb_buffer.sv
// Scoreboard bench for exu_wb_buffer: a queue model is checked against the DUT every cycle,
// plus directed scenarios (reset, latency, stall, push+pop, flush, optional bypass).
module tb_exu_wb_buffer;

    typedef struct packed {
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] res;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_wen, out_valid, out_ready, out_wen;
    logic [4:0]  in_rd, out_rd;
    logic [31:0] in_result, in_pc, out_result, out_pc;
    logic [1:0]  count;
`ifdef EXU_WB_BYPASS_EN
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_hit, rs2_hit;
    logic [31:0] rs1_data, rs2_data;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    ent_t        q[$];
    logic [31:0] pc_ctr = 32'h1000;

    exu_wb_buffer #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wen(in_wen),
        .in_result(in_result), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_wen(out_wen),
        .out_result(out_result), .out_pc(out_pc), .count(count)
`ifdef EXU_WB_BYPASS_EN
       ,.rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_hit(rs1_hit), .rs2_hit(rs2_hit),
        .rs1_data(rs1_data), .rs2_data(rs2_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

`ifdef EXU_WB_BYPASS_EN
    function automatic logic [32:0] bp_model(input logic [4:0] a);
        logic [32:0] r;
        r = 33'd0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (!r[32] && q[i].wen && q[i].rd == a && a != 5'd0) r = {1'b1, q[i].res};
        return r;
    endfunction
`endif

    // Model check and update each cycle, away from the active edge
    always @(negedge clk) begin
        int   sz0;
        ent_t e;
        if (rst) begin
            q.delete();
        end else begin
            sz0 = q.size();
            chk("count", 64'(count), 64'(sz0));
            chk("out_valid", 64'(out_valid), 64'(sz0 != 0));
            chk("in_ready", 64'(in_ready), 64'(sz0 != 2));
            if (sz0 != 0) begin
                chk("out_rd", 64'(out_rd), 64'(q[0].rd));
                chk("out_wen", 64'(out_wen), 64'(q[0].wen));
                chk("out_result", 64'(out_result), 64'(q[0].res));
                chk("out_pc", 64'(out_pc), 64'(q[0].pc));
            end
`ifdef EXU_WB_BYPASS_EN
            begin
                logic [32:0] m1, m2;
                m1 = bp_model(rs1_addr);
                m2 = bp_model(rs2_addr);
                chk("rs1_hit", 64'(rs1_hit), 64'(m1[32]));
                chk("rs2_hit", 64'(rs2_hit), 64'(m2[32]));
                if (m1[32]) chk("rs1_data", 64'(rs1_data), 64'(m1[31:0]));
                if (m2[32]) chk("rs2_data", 64'(rs2_data), 64'(m2[31:0]));
            end
`endif
            if (sz0 != 0 && out_ready) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (in_valid && sz0 != 2) begin
                e.rd  = in_rd;
                e.wen = in_wen && (in_rd != 5'd0);
                e.res = in_result;
                e.pc  = in_pc;
                q.push_back(e);
            end
        end
    end

    task automatic push(input logic [4:0] rd, input logic [31:0] res);
        int   budget;
        logic acc;
        in_valid  = 1'b1;
        in_rd     = rd;
        in_wen    = 1'b1;
        in_result = res;
        in_pc     = pc_ctr;
        pc_ctr    = pc_ctr + 32'd4;
        budget    = 50;
        acc       = 1'b0;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rd = 5'd0; in_wen = 1'b0;
        in_result = 32'd0; in_pc = 32'd0; out_ready = 1'b1;
`ifdef EXU_WB_BYPASS_EN
        rs1_addr = 5'd0; rs2_addr = 5'd0;
`endif
        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_result", 64'(out_result), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 2: single push, one-cycle latency, pop
        push(5'd5, 32'h1234);
        @(negedge clk);
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_rd", 64'(out_rd), 64'd5);
        chk("t2_result", 64'(out_result), 64'h1234);
        cycles(1);
        @(negedge clk);
        chk("t2_count", 64'(count), 64'd0);
        cycles(1);

        // 3: stall with out_ready=0, fill, then drain in order
        out_ready = 1'b0;
        push(5'd1, 32'h11);
        push(5'd2, 32'h22);
        @(negedge clk);
        chk("t3_full", 64'(in_ready), 64'd0);
        fork
            push(5'd3, 32'h33);
            begin cycles(3); out_ready = 1'b1; end
        join
        cycles(3);

        // 4: steady push+pop at count=1
        out_ready = 1'b0;
        push(5'd4, 32'h400);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) push(5'(6 + i), 32'h500 + 32'(i));
        cycles(2);

        // 5: flush at count=2 with in_valid, then flush dropping an accepted push
        out_ready = 1'b0;
        push(5'd7, 32'h70);
        push(5'd8, 32'h80);
        in_valid = 1'b1; in_rd = 5'd9; in_result = 32'h90; flush = 1'b1;
        cycles(1);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_valid", 64'(out_valid), 64'd0);
        push(5'd10, 32'hA0);
        in_valid = 1'b1; in_rd = 5'd11; in_result = 32'hB0; flush = 1'b1;
        cycles(1);
        flush = 1'b0; in_valid = 1'b0;
        cycles(2);
        out_ready = 1'b1;

        // rd=0 push never requests a write
        push(5'd0, 32'hDEAD);
        cycles(2);

`ifdef EXU_WB_BYPASS_EN
        // 6: youngest matching entry wins; x0 never hits
        out_ready = 1'b0;
        push(5'd3, 32'hA);
        push(5'd3, 32'hB);
        rs1_addr = 5'd3; rs2_addr = 5'd0;
        @(negedge clk);
        chk("t6_rs1_hit", 64'(rs1_hit), 64'd1);
        chk("t6_rs1_data", 64'(rs1_data), 64'hB);
        chk("t6_rs2_hit", 64'(rs2_hit), 64'd0);
        cycles(1);
        out_ready = 1'b1;
        cycles(3);
`endif

        // Random traffic with upstream holding stalled data
        begin
            logic acc;
            acc = 1'b1;
            for (int i = 0; i < 400; i++) begin
                if (!(in_valid && !acc)) begin
                    in_valid  = 1'($urandom_range(0, 1));
                    in_rd     = 5'($urandom_range(0, 7));
                    in_wen    = 1'($urandom_range(0, 1));
                    in_result = $urandom;
                    in_pc     = pc_ctr;
                    pc_ctr    = pc_ctr + 32'd4;
                end
                out_ready = 1'($urandom_range(0, 1));
                flush     = ($urandom_range(0, 15) == 0);
`ifdef EXU_WB_BYPASS_EN
                rs1_addr = 5'($urandom_range(0, 7));
                rs2_addr = 5'($urandom_range(0, 7));
`endif
                @(negedge clk);
                acc = in_ready || flush;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0; flush = 1'b0;
        end

        // Reset mid-operation clears data
        out_ready = 1'b0;
        push(5'd12, 32'hC0FFEE);
        rst = 1'b1;
        cycles(1);
        @(negedge clk);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_result", 64'(out_result), 64'd0);
        cycles(1);
        rst = 1'b0;
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
